matrix_mem_arbiter: RTL



---
 rtl/matrix_mem_arbiter_pkg.sv | 18 +
 rtl/matrix_mem_arbiter_if.sv | 47 ++++
 rtl/matrix_mem_arbiter_rr_pick.sv | 36 +++
 rtl/matrix_mem_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/matrix_mem_arbiter_pkg.sv
// Shared definitions for the matrix-memory port: arbiter state encoding,
// requester ids and the default bus widths used by interpreter and loader.
package matrix_mem_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/matrix_mem_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the memory.
// The master view is the arbiter; the slave view is requesters plus memory.
interface matrix_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              a_enable;
    logic              a_readWrite;
    logic [ADDR_W-1:0] a_address;
    logic [DATA_W-1:0] a_data_write;
    logic              a_done;
    logic              a_error;
    logic [DATA_W-1:0] a_data_read;

    logic              b_enable;
    logic              b_readWrite;
    logic [ADDR_W-1:0] b_address;
    logic [DATA_W-1:0] b_data_write;
    logic              b_done;
    logic              b_error;
    logic [DATA_W-1:0] b_data_read;

    logic              mem_enable;
    logic              mem_readWrite;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_write;
    logic [DATA_W-1:0] mem_data_read;
    logic              mem_done;

    modport master (
        input  a_enable, a_readWrite, a_address, a_data_write,
        input  b_enable, b_readWrite, b_address, b_data_write,
        input  mem_data_read, mem_done,
        output a_done, a_error, a_data_read,
        output b_done, b_error, b_data_read,
        output mem_enable, mem_readWrite, mem_address, mem_data_write
    );

    modport slave (
        output a_enable, a_readWrite, a_address, a_data_write,
        output b_enable, b_readWrite, b_address, b_data_write,
        output mem_data_read, mem_done,
        input  a_done, a_error, a_data_read,
        input  b_done, b_error, b_data_read,
        input  mem_enable, mem_readWrite, mem_address, mem_data_write
    );
endinterface

// File: rtl/matrix_mem_arbiter_rr_pick.sv
// Two-way round-robin selector: a lone eligible requester wins outright,
// and when both are eligible the one not served last wins.
module rr_pick
    import matrix_mem_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_served,
    output logic       grant_valid,
    output logic       grant_id
);

    // Decode the eligible vector into a winner
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = PORT_A;
        case (eligible)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = PORT_A;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = PORT_B;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ~last_served;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = PORT_A;
            end
        endcase
    end

endmodule

// File: rtl/matrix_mem_arbiter.sv
// Serialises stack-interpreter (A) and host-loader (B) accesses onto the
// single matrix-memory port. A just-served requester is masked for HOLDOFF
// cycles so a late enable drop is not re-granted; a watchdog aborts
// transactions whose mem_done never comes (TIMEOUT = 0 disables it).
module matrix_mem_arbiter
    import matrix_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int HOLDOFF = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clock,
    input  logic                 reset_n,
    matrix_mem_arbiter_if.master bus,
    output logic                 busy,
    output logic                 grant_b
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e      state_r;
    arb_state_e      state_s;
    logic            last_r;
    logic            win_r;
    logic            busy_r;
    logic            grant_b_r;
    logic [1:0]      hold_a_r;
    logic [1:0]      hold_b_r;
    logic [WD_W-1:0] wd_r;

    logic [1:0]      elig_s;
    logic            pick_valid_s;
    logic            pick_id_s;
    logic            expire_s;
    logic            issue_s;
    logic            finish_s;
    logic            abort_s;

    assign elig_s = {bus.b_enable && (hold_b_r == 2'd0),
                     bus.a_enable && (hold_a_r == 2'd0)};

    rr_pick u_rr_pick (
        .eligible    (elig_s),
        .last_served (last_r),
        .grant_valid (pick_valid_s),
        .grant_id    (pick_id_s)
    );

    assign busy    = busy_r;
    assign grant_b = grant_b_r;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) state_s = ST_ISSUE;
                else              state_s = ST_IDLE;
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (finish_s) state_s = ST_DONE;
                else          state_s = ST_WAIT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes; mem_done in the expiry cycle wins over abort
    always_comb begin
        issue_s  = 1'b0;
        finish_s = 1'b0;
        abort_s  = 1'b0;
        expire_s = (TIMEOUT != 0) && (wd_r == WD_W'(TIMEOUT - 1));
        case (state_r)
            ST_IDLE: issue_s = pick_valid_s;
            ST_WAIT: begin
                finish_s = bus.mem_done || expire_s;
                abort_s  = !bus.mem_done && expire_s;
            end
            default: begin
                issue_s  = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Registered outputs: memory request on grant, completion on finish
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_r             <= PORT_B;
            win_r              <= PORT_A;
            busy_r             <= 1'b0;
            grant_b_r          <= 1'b0;
            bus.mem_enable     <= 1'b0;
            bus.mem_readWrite  <= 1'b0;
            bus.mem_address    <= {ADDR_W{1'b0}};
            bus.mem_data_write <= {DATA_W{1'b0}};
            bus.a_done         <= 1'b0;
            bus.a_error        <= 1'b0;
            bus.a_data_read    <= {DATA_W{1'b0}};
            bus.b_done         <= 1'b0;
            bus.b_error        <= 1'b0;
            bus.b_data_read    <= {DATA_W{1'b0}};
        end else begin
            busy_r      <= (state_s != ST_IDLE);
            bus.a_done  <= 1'b0;
            bus.a_error <= 1'b0;
            bus.b_done  <= 1'b0;
            bus.b_error <= 1'b0;
            if (issue_s) begin
                win_r          <= pick_id_s;
                last_r         <= pick_id_s;
                grant_b_r      <= pick_id_s;
                bus.mem_enable <= 1'b1;
                if (pick_id_s == PORT_B) begin
                    bus.mem_readWrite  <= bus.b_readWrite;
                    bus.mem_address    <= bus.b_address;
                    bus.mem_data_write <= bus.b_data_write;
                end else begin
                    bus.mem_readWrite  <= bus.a_readWrite;
                    bus.mem_address    <= bus.a_address;
                    bus.mem_data_write <= bus.a_data_write;
                end
            end else if (finish_s) begin
                bus.mem_enable <= 1'b0;
                if (win_r == PORT_B) begin
                    bus.b_done  <= 1'b1;
                    bus.b_error <= abort_s;
                    if (!abort_s && bus.mem_readWrite) bus.b_data_read <= bus.mem_data_read;
                end else begin
                    bus.a_done  <= 1'b1;
                    bus.a_error <= abort_s;
                    if (!abort_s && bus.mem_readWrite) bus.a_data_read <= bus.mem_data_read;
                end
            end
        end
    end

    // Hold-off counters: reload the winner on entering DONE, else count down
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_a_r <= 2'd0;
            hold_b_r <= 2'd0;
        end else begin
            if (finish_s && (win_r == PORT_A)) hold_a_r <= 2'(HOLDOFF);
            else if (hold_a_r != 2'd0)         hold_a_r <= hold_a_r - 2'd1;
            if (finish_s && (win_r == PORT_B)) hold_b_r <= 2'(HOLDOFF);
            else if (hold_b_r != 2'd0)         hold_b_r <= hold_b_r - 2'd1;
        end
    end

    // Watchdog: cleared while issuing, counts WAIT cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
